// File: rtl/byte_stream_loader.sv
// Byte-stream front end for the byte-write register: sequential indexed writes, frame length
// checking, and a valid/ack hand-off of each complete frame.
module byte_stream_loader #(
    parameter int unsigned SIZE_IN_BYTES = 12,
    parameter int unsigned BYTE_NUM_SIZE = 16
) (
    input  logic                     CLK,
    input  logic                     ARESET,
    input  logic                     S_VALID,
    output logic                     S_READY,
    input  logic [7:0]               S_DATA,
    input  logic                     S_LAST,
    output logic                     WR_ENABLE,
    output logic [BYTE_NUM_SIZE-1:0] WR_BYTE_NUM,
    output logic [7:0]               WR_VALUE,
    output logic                     FRAME_VALID,
    input  logic                     FRAME_ACK,
    output logic                     FRAME_ERROR
);

    localparam logic [BYTE_NUM_SIZE-1:0] LastIdx = BYTE_NUM_SIZE'(SIZE_IN_BYTES - 1);

    typedef enum logic [1:0] {
        StLoad,
        StCommit,
        StHold,
        StDrain
    } state_e;

    state_e                   r_state;
    logic [BYTE_NUM_SIZE-1:0] r_cnt;
    logic                     r_s_ready;
    logic                     r_wr_en;
    logic [BYTE_NUM_SIZE-1:0] r_wr_num;
    logic [7:0]               r_wr_val;
    logic                     r_frame_valid;
    logic                     r_frame_err;

    state_e                   w_state_d;
    logic [BYTE_NUM_SIZE-1:0] w_cnt_d;
    logic                     w_s_ready_d;
    logic                     w_wr_en_d;
    logic [BYTE_NUM_SIZE-1:0] w_wr_num_d;
    logic [7:0]               w_wr_val_d;
    logic                     w_frame_valid_d;
    logic                     w_frame_err_d;
    logic                     w_accept;

    assign w_accept = S_VALID && r_s_ready;

    always_comb begin
        w_state_d       = r_state;
        w_cnt_d         = r_cnt;
        w_wr_en_d       = 1'b0;
        w_wr_num_d      = r_wr_num;
        w_wr_val_d      = r_wr_val;
        w_frame_valid_d = r_frame_valid;
        w_frame_err_d   = 1'b0;

        unique case (r_state)
            StLoad: begin
                if (w_accept) begin
                    w_wr_en_d  = 1'b1;
                    w_wr_num_d = r_cnt;
                    w_wr_val_d = S_DATA;
                    if (r_cnt == LastIdx) begin
                        w_cnt_d   = '0;
                        w_state_d = S_LAST ? StCommit : StDrain;
                    end else if (S_LAST) begin
                        // Short frame: byte still lands, rest of the register is stale.
                        w_cnt_d       = '0;
                        w_frame_err_d = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            StCommit: begin
                // One idle cycle lets the final write land before the frame is advertised.
                w_frame_valid_d = 1'b1;
                w_state_d       = StHold;
            end
            StHold: begin
                if (FRAME_ACK) begin
                    w_frame_valid_d = 1'b0;
                    w_state_d       = StLoad;
                end
            end
            StDrain: begin
                if (w_accept && S_LAST) begin
                    w_frame_err_d = 1'b1;
                    w_state_d     = StLoad;
                end
            end
            default: begin
                w_state_d = StLoad;
            end
        endcase

        w_s_ready_d = (w_state_d == StLoad) || (w_state_d == StDrain);
    end

    always_ff @(posedge CLK or posedge ARESET) begin
        if (ARESET) begin
            r_state       <= StLoad;
            r_cnt         <= '0;
            r_s_ready     <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_num      <= '0;
            r_wr_val      <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_s_ready     <= w_s_ready_d;
            r_wr_en       <= w_wr_en_d;
            r_wr_num      <= w_wr_num_d;
            r_wr_val      <= w_wr_val_d;
            r_frame_valid <= w_frame_valid_d;
            r_frame_err   <= w_frame_err_d;
        end
    end

    assign S_READY     = r_s_ready;
    assign WR_ENABLE   = r_wr_en;
    assign WR_BYTE_NUM = r_wr_num;
    assign WR_VALUE    = r_wr_val;
    assign FRAME_VALID = r_frame_valid;
    assign FRAME_ERROR = r_frame_err;

endmodule

// File: tb/tb_byte_stream_loader.sv
// Self-checking bench for byte_stream_loader: frame table plus reset corner sequences,
// with a write scoreboard fed at accept time and drained by a negedge monitor.
`timescale 1ns/1ps
module tb_byte_stream_loader;

    localparam int unsigned N  = 12;
    localparam int unsigned BW = 16;

    logic          CLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          S_VALID = 1'b0;
    logic          S_LAST = 1'b0;
    logic [7:0]    S_DATA = 8'h00;
    logic          FRAME_ACK = 1'b0;
    logic          S_READY;
    logic          WR_ENABLE;
    logic [BW-1:0] WR_BYTE_NUM;
    logic [7:0]    WR_VALUE;
    logic          FRAME_VALID;
    logic          FRAME_ERROR;

    byte_stream_loader #(
        .SIZE_IN_BYTES(N),
        .BYTE_NUM_SIZE(BW)
    ) dut (
        .CLK        (CLK),
        .ARESET     (ARESET),
        .S_VALID    (S_VALID),
        .S_READY    (S_READY),
        .S_DATA     (S_DATA),
        .S_LAST     (S_LAST),
        .WR_ENABLE  (WR_ENABLE),
        .WR_BYTE_NUM(WR_BYTE_NUM),
        .WR_VALUE   (WR_VALUE),
        .FRAME_VALID(FRAME_VALID),
        .FRAME_ACK  (FRAME_ACK),
        .FRAME_ERROR(FRAME_ERROR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         len;
        logic [7:0] base;
        bit         gaps;
        bit         bp;
        bit         exp_valid;
        bit         exp_err;
        int         exp_writes;
    } frame_t;

    frame_t          tbl[7];
    logic [BW+7:0]   exp_q[$];
    logic [BW+7:0]   sb_e;
    int              n_cmp = 0;
    int              n_fail = 0;
    int              wr_seen = 0;
    int              err_seen = 0;
    int              cyc = 0;
    int              m_idx = 0;
    bit              m_drain = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!ARESET) begin
            if (WR_ENABLE) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("wr_byte_num", 32'(WR_BYTE_NUM), 32'(sb_e[BW+7:8]));
                    check("wr_value", 32'(WR_VALUE), 32'(sb_e[7:0]));
                end
            end
            if (FRAME_ERROR) err_seen++;
            if (FRAME_VALID) check("write_while_valid", 32'(WR_ENABLE), 32'd0);
        end
    end

    // Reference behaviour of one accepted byte, applied at its accept edge.
    task automatic model(input logic [7:0] d, input bit last);
        if (!m_drain) begin
            exp_q.push_back({m_idx[BW-1:0], d});
            if (m_idx == N - 1) begin
                m_idx   = 0;
                m_drain = !last;
            end else if (last) begin
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end else if (last) begin
            m_drain = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit last, input bit gaps, output bit ok);
        bit rdy;
        ok = 1'b0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            S_VALID = 1'b0;
            @(posedge CLK);
            #1;
        end
        S_VALID = 1'b1;
        S_DATA  = d;
        S_LAST  = last;
        for (int t = 0; t < 50; t++) begin
            rdy = S_READY;
            @(posedge CLK);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        else model(d, last);
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_idx   = 0;
        m_drain = 1'b0;
    endtask

    task automatic run_frame(input frame_t f);
        int w0;
        int e0;
        int c0;
        bit ok;
        w0 = wr_seen;
        e0 = err_seen;
        c0 = 0;
        for (int i = 0; i < f.len; i++) begin
            send(f.base + 8'(i), (i == f.len - 1), f.gaps, ok);
            if (!ok) return;
            if (i == 0) c0 = cyc;
        end
        S_VALID = 1'b0;
        S_LAST  = 1'b0;
        if (!f.gaps) check("burst_cycles", 32'(cyc - c0), 32'(f.len - 1));
        check("ready_after_last", 32'(S_READY), 32'(!f.exp_valid));
        check("valid_after_last", 32'(FRAME_VALID), 32'd0);
        check("error_pulse", 32'(FRAME_ERROR), 32'(f.exp_err));
        @(posedge CLK);
        #1;
        check("valid_after_commit", 32'(FRAME_VALID), 32'(f.exp_valid));
        check("error_one_cycle", 32'(FRAME_ERROR), 32'd0);
        check("write_count", 32'(wr_seen - w0), 32'(f.exp_writes));
        check("error_count", 32'(err_seen - e0), 32'(f.exp_err));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        if (f.exp_valid) begin
            if (f.bp) begin
                S_VALID = 1'b1;
                S_DATA  = 8'hEE;
                for (int k = 0; k < 20; k++) begin
                    @(posedge CLK);
                    #1;
                    check("hold_ready", 32'(S_READY), 32'd0);
                    check("hold_valid", 32'(FRAME_VALID), 32'd1);
                end
                check("hold_no_writes", 32'(wr_seen - w0), 32'(f.exp_writes));
                S_VALID = 1'b0;
            end
            FRAME_ACK = 1'b1;
            @(posedge CLK);
            #1;
            FRAME_ACK = 1'b0;
            check("ack_valid", 32'(FRAME_VALID), 32'd0);
            check("ack_ready", 32'(S_READY), 32'd1);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_s_ready"}, 32'(S_READY), 32'd0);
        check({tag, "_wr_enable"}, 32'(WR_ENABLE), 32'd0);
        check({tag, "_wr_byte_num"}, 32'(WR_BYTE_NUM), 32'd0);
        check({tag, "_wr_value"}, 32'(WR_VALUE), 32'd0);
        check({tag, "_frame_valid"}, 32'(FRAME_VALID), 32'd0);
        check({tag, "_frame_error"}, 32'(FRAME_ERROR), 32'd0);
    endtask

    initial begin
        bit ok;
        // len, base, gaps, back-pressure, valid, error, writes
        tbl[0] = '{12, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 12};
        tbl[1] = '{5,  8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 5};
        tbl[2] = '{12, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0, 12};
        tbl[3] = '{15, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 12};
        tbl[4] = '{12, 8'h50, 1'b1, 1'b0, 1'b1, 1'b0, 12};
        tbl[5] = '{1,  8'h60, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[6] = '{12, 8'h70, 1'b0, 1'b0, 1'b1, 1'b0, 12};

        repeat (2) @(posedge CLK);
        #1;
        check_cleared("in_reset");
        ARESET = 1'b0;
        #1;
        check("ready_before_edge", 32'(S_READY), 32'd0);
        @(posedge CLK);
        #1;
        check("ready_after_release", 32'(S_READY), 32'd1);
        check("idle_wr_enable", 32'(WR_ENABLE), 32'd0);
        check("idle_frame_valid", 32'(FRAME_VALID), 32'd0);

        for (int i = 0; i < 7; i++) run_frame(tbl[i]);

        // Reset after six bytes of a frame.
        for (int i = 0; i < 6; i++) send(8'h80 + 8'(i), 1'b0, 1'b0, ok);
        #1;
        ARESET = 1'b1;
        #1;
        clear_model();
        S_VALID = 1'b0;
        check_cleared("mid_frame_reset");
        @(posedge CLK);
        #1;
        ARESET = 1'b0;
        @(posedge CLK);
        #1;
        run_frame(tbl[2]);

        // Reset while a completed frame is held.
        for (int i = 0; i < 12; i++) send(8'h90 + 8'(i), (i == 11), 1'b0, ok);
        S_VALID = 1'b0;
        S_LAST  = 1'b0;
        @(posedge CLK);
        #1;
        check("hold_before_reset", 32'(FRAME_VALID), 32'd1);
        #2;
        ARESET = 1'b1;
        #1;
        clear_model();
        check_cleared("hold_reset");
        @(posedge CLK);
        #1;
        ARESET = 1'b0;
        @(posedge CLK);
        #1;
        run_frame(tbl[6]);

        repeat (2) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
